// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution MAC sequencer.
//   state_e      FSM state encoding (idle, fetch, last tap, output, done)
//   DEF_*        default image/filter geometry
//   OUT_W/OUT_H  output feature-map size for the default geometry
//   TAPS         taps per window for the default geometry
//   out_dim()    output side length for a given image side and filter side
//   width_of()   bits needed to count 0..n-1 (never less than 1)
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLast,
    StOut,
    StDone
  } state_e;

  localparam int unsigned DEF_IMG_W = 28;
  localparam int unsigned DEF_IMG_H = 28;
  localparam int unsigned DEF_K     = 3;

  localparam int unsigned OUT_W = DEF_IMG_W - DEF_K + 1;
  localparam int unsigned OUT_H = DEF_IMG_H - DEF_K + 1;
  localparam int unsigned TAPS  = DEF_K * DEF_K;

  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// conv_mac_sequencer_if: groups every non-clock signal of the sequencer.
//   control : start, busy, done
//   RAM/MAC : img_addr, filt_addr, mac_enable, one_conv_done, mac_result
//   output  : out_data, out_addr, out_valid, out_ready (valid/ready stream)
// master = sequencer side, slave = surrounding RAMs/MAC/consumer side.
interface conv_mac_sequencer_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned FADDR_W = 4
);
  logic               start;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  img_addr;
  logic [FADDR_W-1:0] filt_addr;
  logic               mac_enable;
  logic               one_conv_done;
  logic [DATA_W-1:0]  mac_result;
  logic [DATA_W-1:0]  out_data;
  logic [ADDR_W-1:0]  out_addr;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  start, mac_result, out_ready,
    output busy, done, img_addr, filt_addr, mac_enable, one_conv_done,
           out_data, out_addr, out_valid
  );

  modport slave (
    output start, mac_result, out_ready,
    input  busy, done, img_addr, filt_addr, mac_enable, one_conv_done,
           out_data, out_addr, out_valid
  );
endinterface

// File: rtl/window_addr_gen.sv
// window_addr_gen: window/tap counters and incremental address generation.
//   clk, reset          clock, synchronous active-high reset
//   init                restart at window (0,0), tap 0
//   step_tap            advance to the next tap inside the window (kx fastest)
//   step_win            advance to tap 0 of the next window (ox fastest)
//   img_addr/filt_addr  registered RAM read addresses of the current tap
//   out_idx             raster index of the current window
//   first_tap/last_tap  current tap is tap 0 / tap K*K-1
//   last_win            current window is the final one
// Addresses are kept as running sums so no multipliers are needed.
module window_addr_gen import conv_pkg::*; #(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned K       = DEF_K,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned FADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               step_tap,
  input  logic               step_win,
  output logic [ADDR_W-1:0]  img_addr,
  output logic [FADDR_W-1:0] filt_addr,
  output logic [ADDR_W-1:0]  out_idx,
  output logic               first_tap,
  output logic               last_tap,
  output logic               last_win
);

  localparam int unsigned OutW = out_dim(IMG_W, K);
  localparam int unsigned OutH = out_dim(IMG_H, K);
  localparam int unsigned KW   = width_of(K);
  localparam int unsigned OXW  = width_of(OutW);
  localparam int unsigned OYW  = width_of(OutH);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(IMG_W);

  logic [KW-1:0]      kx_q, kx_d, ky_q, ky_d;
  logic [OXW-1:0]     ox_q, ox_d;
  logic [OYW-1:0]     oy_q, oy_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;  // oy*IMG_W
  logic [ADDR_W-1:0]  win_base_q, win_base_d;  // oy*IMG_W + ox
  logic [ADDR_W-1:0]  tap_row_q, tap_row_d;    // win_base + ky*IMG_W
  logic [ADDR_W-1:0]  img_addr_q, img_addr_d;
  logic [FADDR_W-1:0] filt_q, filt_d;
  logic [ADDR_W-1:0]  out_idx_q, out_idx_d;

  always_comb begin
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    row_base_d = row_base_q;
    win_base_d = win_base_q;
    tap_row_d  = tap_row_q;
    img_addr_d = img_addr_q;
    filt_d     = filt_q;
    out_idx_d  = out_idx_q;
    if (init) begin
      kx_d       = '0;
      ky_d       = '0;
      ox_d       = '0;
      oy_d       = '0;
      row_base_d = '0;
      win_base_d = '0;
      tap_row_d  = '0;
      img_addr_d = '0;
      filt_d     = '0;
      out_idx_d  = '0;
    end else if (step_win) begin
      if (ox_q == OXW'(OutW - 1)) begin
        ox_d       = '0;
        oy_d       = oy_q + 1'b1;
        row_base_d = row_base_q + RowStep;
        win_base_d = row_base_q + RowStep;
      end else begin
        ox_d       = ox_q + 1'b1;
        win_base_d = win_base_q + 1'b1;
      end
      tap_row_d  = win_base_d;
      img_addr_d = win_base_d;
      kx_d       = '0;
      ky_d       = '0;
      filt_d     = '0;
      out_idx_d  = out_idx_q + 1'b1;
    end else if (step_tap) begin
      if (kx_q == KW'(K - 1)) begin
        kx_d       = '0;
        ky_d       = ky_q + 1'b1;
        tap_row_d  = tap_row_q + RowStep;
        img_addr_d = tap_row_q + RowStep;
      end else begin
        kx_d       = kx_q + 1'b1;
        img_addr_d = img_addr_q + 1'b1;
      end
      filt_d = filt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      row_base_q <= '0;
      win_base_q <= '0;
      tap_row_q  <= '0;
      img_addr_q <= '0;
      filt_q     <= '0;
      out_idx_q  <= '0;
    end else begin
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      row_base_q <= row_base_d;
      win_base_q <= win_base_d;
      tap_row_q  <= tap_row_d;
      img_addr_q <= img_addr_d;
      filt_q     <= filt_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign img_addr  = img_addr_q;
  assign filt_addr = filt_q;
  assign out_idx   = out_idx_q;
  assign first_tap = (filt_q == '0);
  assign last_tap  = (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1));
  assign last_win  = (ox_q == OXW'(OutW - 1)) && (oy_q == OYW'(OutH - 1));

endmodule

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: walks a KxK window over an IMG_W x IMG_H image, issues
// per-tap image/filter RAM addresses, drives the shared MAC's enable/last-tap
// strobes aligned with the 1-cycle RAM read data, and presents each window's
// MAC result on a valid/ready output register.
//   clk, reset  clock, synchronous active-high reset
//   bus         conv_mac_sequencer_if.master: start/busy/done, RAM addresses,
//               mac_enable/one_conv_done/mac_result, out_* stream
module conv_mac_sequencer import conv_pkg::*; #(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned K       = DEF_K,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned FADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_mac_sequencer_if.master  bus
);

  state_e state_q, state_d;

  logic               init, step_tap, step_win;
  logic               first_tap, last_tap, last_win;
  logic [ADDR_W-1:0]  img_addr, out_idx;
  logic [FADDR_W-1:0] filt_addr;
  logic               mac_enable, one_conv_done;

  logic [DATA_W-1:0]  out_data_q;
  logic [ADDR_W-1:0]  out_addr_q;
  logic               out_valid_q;
  logic               handshake;

  window_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .K       (K),
    .ADDR_W  (ADDR_W),
    .FADDR_W (FADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .step_tap  (step_tap),
    .step_win  (step_win),
    .img_addr  (img_addr),
    .filt_addr (filt_addr),
    .out_idx   (out_idx),
    .first_tap (first_tap),
    .last_tap  (last_tap),
    .last_win  (last_win)
  );

  assign handshake = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    init          = 1'b0;
    step_tap      = 1'b0;
    step_win      = 1'b0;
    mac_enable    = 1'b0;
    one_conv_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          init    = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // RAM data lags the address by one cycle, so tap 0 carries no data yet.
        mac_enable = !first_tap;
        if (last_tap) state_d = StLast;
        else          step_tap = 1'b1;
      end
      StLast: begin
        mac_enable    = 1'b1;
        one_conv_done = 1'b1;
        state_d       = StOut;
      end
      StOut: begin
        if (handshake) begin
          if (last_win) begin
            state_d = StDone;
          end else begin
            step_win = 1'b1;
            state_d  = StFetch;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (state_q == StLast) begin
      out_data_q  <= bus.mac_result;
      out_addr_q  <= out_idx;
      out_valid_q <= 1'b1;
    end else if (handshake) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
  assign bus.img_addr      = img_addr;
  assign bus.filt_addr     = filt_addr;
  assign bus.mac_enable    = mac_enable;
  assign bus.one_conv_done = one_conv_done;
  assign bus.out_data      = out_data_q;
  assign bus.out_addr      = out_addr_q;
  assign bus.out_valid     = out_valid_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer on a 5x5 image with a 3x3 filter. Image/filter
// RAMs and the dot_product MAC are modelled behaviourally; window results are
// compared against a direct nested-loop convolution of the RAM contents.
module tb_conv_mac_sequencer;

  localparam int unsigned IMG_W   = 5;
  localparam int unsigned IMG_H   = 5;
  localparam int unsigned K       = 3;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned FADDR_W = 4;
  localparam int OW   = IMG_W - K + 1;
  localparam int OH   = IMG_H - K + 1;
  localparam int NOUT = OW * OH;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_mac_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FADDR_W(FADDR_W)) bus ();

  conv_mac_sequencer #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .K       (K),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .FADDR_W (FADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAMs with 1-cycle read latency and a behavioural dot_product MAC.
  logic [DATA_W-1:0] img_mem  [1024];
  logic [DATA_W-1:0] filt_mem [16];
  logic [DATA_W-1:0] img_q, filt_q, acc;

  always @(posedge clk) begin
    img_q  <= img_mem[bus.img_addr];
    filt_q <= filt_mem[bus.filt_addr];
    if (reset || bus.one_conv_done) acc <= '0;
    else if (bus.mac_enable)        acc <= acc + img_q * filt_q;
  end

  assign bus.mac_result = bus.one_conv_done ? DATA_W'(acc + img_q * filt_q) : '0;

  // Every accepted output, in arrival order.
  logic [ADDR_W-1:0] got_addr [$];
  logic [DATA_W-1:0] got_data [$];
  always @(posedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      got_addr.push_back(bus.out_addr);
      got_data.push_back(bus.out_data);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] ref_out(input int idx);
    int ox = idx % OW;
    int oy = idx / OW;
    logic [DATA_W-1:0] sum = '0;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        sum += img_mem[(oy + ky) * IMG_W + ox + kx] * filt_mem[ky * K + kx];
    return sum;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_count"}, got_addr.size(), NOUT);
    for (int i = 0; i < NOUT && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], i);
      check($sformatf("%s_data%0d", tag, i), got_data[i], ref_out(i));
    end
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_mac_en"},    bus.mac_enable, 0);
    check({tag, "_ocd"},       bus.one_conv_done, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_img_addr"},  bus.img_addr, 0);
    check({tag, "_filt_addr"}, bus.filt_addr, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_out_addr"},  bus.out_addr, 0);
  endtask

  // Called at a negedge with start idle; returns at sample n=1 (first busy cycle).
  task automatic start_pass();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Steps from sample n_in until done is seen; n_out is the sample index of done.
  task automatic run_to_done(input bit rnd, input int n_in, output int n_out);
    int n = n_in;
    while (!bus.done && n < LIMIT) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (!bus.done) check("done_timeout", 0, 1);
    bus.out_ready = 1'b1;
    n_out = n;
  endtask

  task automatic fill_random();
    for (int i = 0; i < IMG_W * IMG_H; i++) img_mem[i] = DATA_W'($urandom_range(0, 255));
    for (int i = 0; i < K * K; i++)         filt_mem[i] = DATA_W'($urandom_range(0, 255));
  endtask

  typedef struct {
    int img;
    int filt;
    bit me;
    bit ocd;
    bit ov;
  } tap_vec_t;

  tap_vec_t tv [11];

  initial begin
    int n;
    logic [DATA_W-1:0] snap_data;
    logic [ADDR_W-1:0] snap_oaddr, snap_img;
    logic [FADDR_W-1:0] snap_filt;
    bit stalled;

    // Expected first-window behaviour, samples n=1..11 after the start edge.
    tv[0]  = '{0,  0, 0, 0, 0};
    tv[1]  = '{1,  1, 1, 0, 0};
    tv[2]  = '{2,  2, 1, 0, 0};
    tv[3]  = '{5,  3, 1, 0, 0};
    tv[4]  = '{6,  4, 1, 0, 0};
    tv[5]  = '{7,  5, 1, 0, 0};
    tv[6]  = '{10, 6, 1, 0, 0};
    tv[7]  = '{11, 7, 1, 0, 0};
    tv[8]  = '{12, 8, 1, 0, 0};
    tv[9]  = '{12, 8, 1, 1, 0};
    tv[10] = '{12, 8, 0, 0, 1};

    for (int i = 0; i < 1024; i++) img_mem[i] = '0;
    for (int i = 0; i < 16; i++)   filt_mem[i] = '0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // All-ones image and filter: first-window address/strobe sequence.
    for (int i = 0; i < IMG_W * IMG_H; i++) img_mem[i] = 1;
    for (int i = 0; i < K * K; i++)         filt_mem[i] = 1;
    start_pass();
    for (int i = 0; i < 11; i++) begin
      check($sformatf("win0_img_addr_n%0d", i + 1),  bus.img_addr,      tv[i].img);
      check($sformatf("win0_filt_addr_n%0d", i + 1), bus.filt_addr,     tv[i].filt);
      check($sformatf("win0_mac_en_n%0d", i + 1),    bus.mac_enable,    tv[i].me);
      check($sformatf("win0_ocd_n%0d", i + 1),       bus.one_conv_done, tv[i].ocd);
      check($sformatf("win0_valid_n%0d", i + 1),     bus.out_valid,     tv[i].ov);
      check($sformatf("win0_busy_n%0d", i + 1),      bus.busy,          1);
      tick();
    end
    run_to_done(1'b0, 12, n);
    check("ones_done_cycle", n, 100);
    for (int i = 0; i < got_data.size(); i++) check($sformatf("ones_val%0d", i), got_data[i], 9);
    check_outputs("ones");
    tick();
    check("ones_done_pulse", bus.done, 0);
    check("ones_idle_busy", bus.busy, 0);

    // Ramp image with a 5-cycle stall on output 4.
    for (int i = 0; i < IMG_W * IMG_H; i++) img_mem[i] = DATA_W'(i);
    start_pass();
    stalled = 1'b0;
    n = 1;
    while (!bus.done && n < LIMIT) begin
      if (!stalled && bus.out_valid && bus.out_addr == 4) begin
        stalled    = 1'b1;
        snap_data  = bus.out_data;
        snap_oaddr = bus.out_addr;
        snap_img   = bus.img_addr;
        snap_filt  = bus.filt_addr;
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          n++;
          check($sformatf("stall%0d_valid", s),    bus.out_valid, 1);
          check($sformatf("stall%0d_data", s),     bus.out_data, snap_data);
          check($sformatf("stall%0d_oaddr", s),    bus.out_addr, snap_oaddr);
          check($sformatf("stall%0d_mac_en", s),   bus.mac_enable, 0);
          check($sformatf("stall%0d_img_addr", s), bus.img_addr, snap_img);
          check($sformatf("stall%0d_filt", s),     bus.filt_addr, snap_filt);
        end
        bus.out_ready = 1'b1;
      end
      tick();
      n++;
    end
    check("ramp_stall_seen", stalled, 1);
    check("ramp_done_seen", bus.done, 1);
    check("ramp_done_cycle", n, 105);
    if (got_data.size() == NOUT) begin
      check("ramp_out0", got_data[0], 54);
      check("ramp_out4", got_data[4], 108);
      check("ramp_out8", got_data[8], 162);
    end
    check_outputs("ramp");
    tick();

    // Reset at tap 4 of window 2 aborts the pass; a fresh pass is then correct.
    for (int i = 0; i < IMG_W * IMG_H; i++) img_mem[i] = 1;
    start_pass();
    n = 1;
    while (!(got_addr.size() == 2 && bus.busy && !bus.out_valid && bus.filt_addr == 4)
           && n < LIMIT) begin
      tick();
      n++;
    end
    check("abort_point_n", n, 27);
    reset = 1'b1;
    tick();
    check_idle_outputs("abort");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("abort_no_done%0d", i), bus.done, 0);
    end
    got_addr.delete();
    got_data.delete();
    start_pass();
    run_to_done(1'b0, 1, n);
    check("fresh_done_cycle", n, 100);
    check_outputs("fresh");
    tick();

    // Start pulsed while busy is ignored; start held through DONE relaunches.
    fill_random();
    start_pass();
    n = 1;
    while (!bus.done && n < LIMIT) begin
      if (n == 30)      bus.start = 1'b1;
      else if (n < 95)  bus.start = 1'b0;
      else              bus.start = 1'b1;
      tick();
      n++;
    end
    check("busy_start_done_cycle", n, 100);
    check_outputs("busy_start");
    tick();
    check("held_start_idle_busy", bus.busy, 0);
    check("held_start_idle_done", bus.done, 0);
    tick();
    bus.start = 1'b0;
    check("held_start_relaunch_busy", bus.busy, 1);
    check("held_start_relaunch_img", bus.img_addr, 0);
    check("held_start_relaunch_filt", bus.filt_addr, 0);
    run_to_done(1'b1, 1, n);
    check_outputs("relaunch");
    tick();

    // Random data with random backpressure.
    for (int p = 0; p < 3; p++) begin
      fill_random();
      start_pass();
      run_to_done(1'b1, 1, n);
      check($sformatf("rand%0d_done_min", p), (n >= 100) ? 1 : 0, 1);
      check_outputs($sformatf("rand%0d", p));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
